// File: rtl/bmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bmd_pkg                                                         |
// | Brief  : Shared category encodings and default grading thresholds for    |
// |          the bone-mineral-density classifier.                            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package bmd_pkg;

    // Category encodings driven on bmd.category (2'b11 is never produced)
    localparam logic [1:0] CAT_NORMAL      = 2'b00;
    localparam logic [1:0] CAT_OSTEOPENIA  = 2'b01;
    localparam logic [1:0] CAT_OSTEOPOROSIS = 2'b10;

    // Default thresholds: codes 0..2 normal, 3..5 osteopenia, 6..7 osteoporosis
    localparam logic [2:0] DEF_NORMAL_MAX     = 3'd2;
    localparam logic [2:0] DEF_OSTEOPENIA_MAX = 3'd5;
    localparam int         DEF_CNT_W          = 8;

endpackage : bmd_pkg
`default_nettype wire

// File: rtl/bmd_grade.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bmd_grade                                                       |
// | Brief  : Purely combinational grading of a 3-bit BMD range code into a   |
// |          2-bit category.                                                |
// | Ports  : bmdrange [2:0] in  - range code, 0 = best, 7 = worst            |
// |          category [1:0] out - CAT_NORMAL / CAT_OSTEOPENIA /              |
// |                               CAT_OSTEOPOROSIS                           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module bmd_grade
    import bmd_pkg::*;
#(
    parameter logic [2:0] NORMAL_MAX     = DEF_NORMAL_MAX,
    parameter logic [2:0] OSTEOPENIA_MAX = DEF_OSTEOPENIA_MAX
) (
    input  logic [2:0] bmdrange,
    output logic [1:0] category
);

    always_comb begin
        category = CAT_OSTEOPOROSIS;
        if (bmdrange <= NORMAL_MAX) begin
            category = CAT_NORMAL;
        end else if (bmdrange <= OSTEOPENIA_MAX) begin
            category = CAT_OSTEOPENIA;
        end
    end

endmodule : bmd_grade
`default_nettype wire

// File: rtl/bmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bmd                                                             |
// | Brief  : Bone-mineral-density classifier. Grades each accepted range     |
// |          code, drives registered mutually exclusive normal/abnormal      |
// |          flags plus category, pulses out_valid for one cycle per result  |
// |          and keeps a saturating count of abnormal samples.               |
// | Ports  : clk            in  - rising-edge clock                          |
// |          rst            in  - asynchronous active-high reset             |
// |          bmd_valid      in  - bmdrange sampled when high                 |
// |          bmdrange [2:0] in  - range code                                 |
// |          clear_count    in  - synchronous clear of abnormal_count        |
// |          normal         out - last accepted sample graded normal         |
// |          abnormal       out - last accepted sample graded abnormal       |
// |          category [1:0] out - grade of last accepted sample              |
// |          out_valid      out - one-cycle pulse per new result             |
// |          abnormal_count out - saturating abnormal-sample count           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module bmd
    import bmd_pkg::*;
#(
    parameter logic [2:0] NORMAL_MAX     = DEF_NORMAL_MAX,
    parameter logic [2:0] OSTEOPENIA_MAX = DEF_OSTEOPENIA_MAX,
    parameter int         CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bmd_valid,
    input  logic [2:0]       bmdrange,
    input  logic             clear_count,
    output logic             normal,
    output logic             abnormal,
    output logic [1:0]       category,
    output logic             out_valid,
    output logic [CNT_W-1:0] abnormal_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]       w_cat;
    logic             w_is_abnormal;

    logic             r_normal;
    logic             r_abnormal;
    logic [1:0]       r_category;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;

    bmd_grade #(
        .NORMAL_MAX     (NORMAL_MAX),
        .OSTEOPENIA_MAX (OSTEOPENIA_MAX)
    ) u_grade (
        .bmdrange (bmdrange),
        .category (w_cat)
    );

    assign w_is_abnormal = (w_cat != CAT_NORMAL);

    // Result registers only load on an accepted sample, so an undefined
    // bmdrange while bmd_valid is low never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_normal    <= 1'b0;
            r_abnormal  <= 1'b0;
            r_category  <= CAT_NORMAL;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bmd_valid;
            if (bmd_valid) begin
                r_category <= w_cat;
                r_normal   <= ~w_is_abnormal;
                r_abnormal <= w_is_abnormal;
            end
        end
    end

    // Clear wins over a simultaneous abnormal sample; the count sticks at max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear_count) begin
            r_count <= '0;
        end else if (bmd_valid && w_is_abnormal && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign normal         = r_normal;
    assign abnormal       = r_abnormal;
    assign category       = r_category;
    assign out_valid      = r_out_valid;
    assign abnormal_count = r_count;

endmodule : bmd
`default_nettype wire

// File: tb/tb_bmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_bmd                                                          |
// | Brief  : Self-checking bench for bmd: a behavioural model checked every  |
// |          cycle, plus directed vectors with literal expectations.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_bmd;

    logic       clk;
    logic       rst;
    logic       bmd_valid;
    logic [2:0] bmdrange;
    logic       clear_count;
    logic       normal;
    logic       abnormal;
    logic [1:0] category;
    logic       out_valid;
    logic [7:0] abnormal_count;

    int total = 0;
    int bad   = 0;

    bmd u_dut (
        .clk            (clk),
        .rst            (rst),
        .bmd_valid      (bmd_valid),
        .bmdrange       (bmdrange),
        .clear_count    (clear_count),
        .normal         (normal),
        .abnormal       (abnormal),
        .category       (category),
        .out_valid      (out_valid),
        .abnormal_count (abnormal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Grade by the plain rule: 0..2 normal, 3..5 osteopenia, 6..7 osteoporosis.
    function automatic int grade(input int code);
        if (code <= 2) return 0;
        if (code <= 5) return 1;
        return 2;
    endfunction

    int m_cat;
    bit m_seen;
    bit m_ov;
    int m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cat  <= 0;
            m_seen <= 1'b0;
            m_ov   <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_ov <= bmd_valid;
            if (bmd_valid) begin
                m_cat  <= grade(int'(bmdrange));
                m_seen <= 1'b1;
            end
            if (clear_count)
                m_cnt <= 0;
            else if (bmd_valid && grade(int'(bmdrange)) != 0)
                m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        check("m_normal",   {31'd0, normal},         {31'd0, m_seen && m_cat == 0});
        check("m_abnormal", {31'd0, abnormal},       {31'd0, m_seen && m_cat != 0});
        check("m_category", {30'd0, category},       m_cat);
        check("m_outvalid", {31'd0, out_valid},      {31'd0, m_ov});
        check("m_count",    {24'd0, abnormal_count}, m_cnt);
        if (m_seen)
            check("m_onehot", {31'd0, normal ^ abnormal}, 32'd1);
    end

    // Apply one cycle of inputs; returns #1 after the edge that samples them.
    task automatic drive(input logic v, input logic [2:0] code, input logic clr);
        bmd_valid   = v;
        bmdrange    = code;
        clear_count = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cat [8];
        exp_cat = '{0, 0, 0, 1, 1, 1, 2, 2};

        rst = 1'b1; bmd_valid = 1'b0; bmdrange = 3'd0; clear_count = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_normal",   {31'd0, normal},         0);
        check("rst_abnormal", {31'd0, abnormal},       0);
        check("rst_ov",       {31'd0, out_valid},      0);
        check("rst_count",    {24'd0, abnormal_count}, 0);

        // Test 1: reset asserted mid-run, sample present during reset ignored
        drive(1'b1, 3'd7, 1'b0);
        drive(1'b1, 3'd6, 1'b0);
        check("pre_rst_abn", {31'd0, abnormal}, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_abn", {31'd0, abnormal},       0);
        check("mid_rst_cnt", {24'd0, abnormal_count}, 0);
        check("mid_rst_ov",  {31'd0, out_valid},      0);
        bmd_valid = 1'b1; bmdrange = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        bmd_valid = 1'b0; rst = 1'b0;
        drive(1'b0, 3'd7, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        check("post_rst_norm", {31'd0, normal},         0);
        check("post_rst_abn",  {31'd0, abnormal},       0);
        check("post_rst_cnt",  {24'd0, abnormal_count}, 0);

        // Test 2: back-to-back samples 000,111,101,010
        drive(1'b1, 3'b000, 1'b0);
        check("t2a_norm", {31'd0, normal}, 1);
        check("t2a_cat",  {30'd0, category}, 0);
        check("t2a_ov",   {31'd0, out_valid}, 1);
        drive(1'b1, 3'b111, 1'b0);
        check("t2b_abn", {31'd0, abnormal}, 1);
        check("t2b_cat", {30'd0, category}, 2);
        check("t2b_ov",  {31'd0, out_valid}, 1);
        drive(1'b1, 3'b101, 1'b0);
        check("t2c_abn", {31'd0, abnormal}, 1);
        check("t2c_cat", {30'd0, category}, 1);
        check("t2c_ov",  {31'd0, out_valid}, 1);
        drive(1'b1, 3'b010, 1'b0);
        check("t2d_norm", {31'd0, normal}, 1);
        check("t2d_cat",  {30'd0, category}, 0);
        check("t2d_ov",   {31'd0, out_valid}, 1);
        check("t2_count", {24'd0, abnormal_count}, 2);

        // Test 3: hold while bmd_valid low, bmdrange toggling and undefined
        drive(1'b1, 3'b101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, (i == 2) ? 3'bxxx : 3'(i * 3 + 1), 1'b0);
            check("t3_abn", {31'd0, abnormal}, 1);
            check("t3_cat", {30'd0, category}, 1);
            check("t3_ov",  {31'd0, out_valid}, 0);
        end
        check("t3_count", {24'd0, abnormal_count}, 3);

        // Test 4: boundary codes
        drive(1'b1, 3'b010, 1'b0); check("t4_010", {30'd0, category}, 0);
        drive(1'b1, 3'b011, 1'b0); check("t4_011", {30'd0, category}, 1);
        drive(1'b1, 3'b101, 1'b0); check("t4_101", {30'd0, category}, 1);
        drive(1'b1, 3'b110, 1'b0); check("t4_110", {30'd0, category}, 2);

        // Test 5: saturation, then clear with a simultaneous abnormal sample
        for (int i = 0; i < 300; i++) drive(1'b1, 3'b111, 1'b0);
        check("t5_sat", {24'd0, abnormal_count}, 255);
        drive(1'b1, 3'b111, 1'b1);
        check("t5_clr_cnt", {24'd0, abnormal_count}, 0);
        check("t5_clr_abn", {31'd0, abnormal}, 1);
        drive(1'b0, 3'b000, 1'b1);
        check("t5_clr_hold", {31'd0, abnormal}, 1);
        drive(1'b1, 3'b100, 1'b0);
        check("t5_recount", {24'd0, abnormal_count}, 1);

        // Test 6: exhaustive sweep against literal table
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 3'(c), 1'b0);
            check("t6_cat", {30'd0, category}, exp_cat[c]);
            check("t6_xor", {31'd0, normal ^ abnormal}, 1);
        end

        drive(1'b0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bmd
`default_nettype wire
